// File: rtl/rx_block_lock_fsm.sv
// 64b/66b receive block-lock state machine: judges sync headers, acquires/loses
// block lock and requests bitslip from the SERDES to hunt for alignment.
module rx_block_lock_fsm #(
  parameter int HDR_WIDTH           = 2,
  parameter int SH_WINDOW           = 64,
  parameter int INVALID_LIMIT       = 16,
  parameter int BITSLIP_HIGH_CYCLES = 1,
  parameter int BITSLIP_LOW_CYCLES  = 8,
  parameter int CNT_WIDTH           = 16
) (
  input  logic                 clk_tb,
  input  logic                 rx_rst_tb,
  input  logic [HDR_WIDTH-1:0] serdes_rx_hdr,
  input  logic                 serdes_rx_hdr_valid,
  output logic                 serdes_rx_bitslip,
  output logic                 rx_block_lock,
  output logic                 rx_bad_hdr,
  output logic [CNT_WIDTH-1:0] inv_hdr_count,
  output logic [CNT_WIDTH-1:0] lock_loss_count
);

  localparam int SH_W       = $clog2(SH_WINDOW + 1);
  localparam int SLIP_TOTAL = BITSLIP_HIGH_CYCLES + BITSLIP_LOW_CYCLES;
  localparam int SLIP_W     = $clog2(SLIP_TOTAL + 1);

  typedef enum logic {TEST, SLIP} state_t;

  state_t              state, state_n;
  logic [SH_W-1:0]     sh_cnt, sh_cnt_n, sh_inc;
  logic [SH_W-1:0]     inv_cnt, inv_cnt_n, inv_inc;
  logic [SLIP_W-1:0]   slip_cnt, slip_cnt_n, slip_inc;
  logic                lock_n, bitslip_n, bad_n;
  logic [CNT_WIDTH-1:0] inv_hdr_count_n, lock_loss_count_n;
  logic                counted, hdr_invalid;

  assign hdr_invalid = (serdes_rx_hdr != HDR_WIDTH'(1)) && (serdes_rx_hdr != HDR_WIDTH'(2));
  assign counted     = serdes_rx_hdr_valid && (state == TEST);
  assign sh_inc      = sh_cnt + SH_W'(1);
  assign inv_inc     = inv_cnt + SH_W'(hdr_invalid);
  assign slip_inc    = slip_cnt + SLIP_W'(1);

  // Invalid-limit is tested before window end so a window-closing header can still drop lock.
  always_comb begin
    state_n           = state;
    sh_cnt_n          = sh_cnt;
    inv_cnt_n         = inv_cnt;
    slip_cnt_n        = slip_cnt;
    lock_n            = rx_block_lock;
    bitslip_n         = 1'b0;
    bad_n             = 1'b0;
    inv_hdr_count_n   = inv_hdr_count;
    lock_loss_count_n = lock_loss_count;

    if (state == SLIP) begin
      if (slip_inc == SLIP_W'(SLIP_TOTAL)) begin
        state_n    = TEST;
        slip_cnt_n = '0;
      end else begin
        slip_cnt_n = slip_inc;
        bitslip_n  = (slip_inc < SLIP_W'(BITSLIP_HIGH_CYCLES));
      end
    end else if (counted) begin
      if (hdr_invalid) begin
        bad_n = 1'b1;
        if (inv_hdr_count != '1)
          inv_hdr_count_n = inv_hdr_count + CNT_WIDTH'(1);
      end
      if (!rx_block_lock) begin
        if (hdr_invalid) begin
          state_n    = SLIP;
          sh_cnt_n   = '0;
          inv_cnt_n  = '0;
          slip_cnt_n = '0;
          bitslip_n  = 1'b1;
        end else if (sh_inc == SH_W'(SH_WINDOW)) begin
          lock_n   = 1'b1;
          sh_cnt_n = '0;
        end else begin
          sh_cnt_n = sh_inc;
        end
      end else begin
        if (inv_inc == SH_W'(INVALID_LIMIT)) begin
          lock_n     = 1'b0;
          state_n    = SLIP;
          sh_cnt_n   = '0;
          inv_cnt_n  = '0;
          slip_cnt_n = '0;
          bitslip_n  = 1'b1;
          if (lock_loss_count != '1)
            lock_loss_count_n = lock_loss_count + CNT_WIDTH'(1);
        end else if (sh_inc == SH_W'(SH_WINDOW)) begin
          sh_cnt_n  = '0;
          inv_cnt_n = '0;
        end else begin
          sh_cnt_n  = sh_inc;
          inv_cnt_n = inv_inc;
        end
      end
    end
  end

  always_ff @(posedge clk_tb or posedge rx_rst_tb) begin
    if (rx_rst_tb) begin
      state             <= TEST;
      sh_cnt            <= '0;
      inv_cnt           <= '0;
      slip_cnt          <= '0;
      rx_block_lock     <= 1'b0;
      serdes_rx_bitslip <= 1'b0;
      rx_bad_hdr        <= 1'b0;
      inv_hdr_count     <= '0;
      lock_loss_count   <= '0;
    end else begin
      state             <= state_n;
      sh_cnt            <= sh_cnt_n;
      inv_cnt           <= inv_cnt_n;
      slip_cnt          <= slip_cnt_n;
      rx_block_lock     <= lock_n;
      serdes_rx_bitslip <= bitslip_n;
      rx_bad_hdr        <= bad_n;
      inv_hdr_count     <= inv_hdr_count_n;
      lock_loss_count   <= lock_loss_count_n;
    end
  end

endmodule

// File: tb/tb_rx_block_lock_fsm.sv
// Self-checking bench for rx_block_lock_fsm: vector table, directed corner
// sequences and randomized traffic against a cycle-level behavioural model.
module tb_rx_block_lock_fsm;

  localparam int WINDOW     = 64;
  localparam int INV_LIMIT  = 16;
  localparam int SLIP_HIGH  = 1;
  localparam int SLIP_TOTAL = 9;

  logic        clk_tb = 1'b0;
  logic        rx_rst_tb = 1'b1;
  logic [1:0]  serdes_rx_hdr = 2'b10;
  logic        serdes_rx_hdr_valid = 1'b0;
  logic        serdes_rx_bitslip;
  logic        rx_block_lock;
  logic        rx_bad_hdr;
  logic [15:0] inv_hdr_count;
  logic [15:0] lock_loss_count;

  rx_block_lock_fsm dut (
    .clk_tb              (clk_tb),
    .rx_rst_tb           (rx_rst_tb),
    .serdes_rx_hdr       (serdes_rx_hdr),
    .serdes_rx_hdr_valid (serdes_rx_hdr_valid),
    .serdes_rx_bitslip   (serdes_rx_bitslip),
    .rx_block_lock       (rx_block_lock),
    .rx_bad_hdr          (rx_bad_hdr),
    .inv_hdr_count       (inv_hdr_count),
    .lock_loss_count     (lock_loss_count)
  );

  always #5 clk_tb = ~clk_tb;

  int total = 0;
  int bad   = 0;

  // Behavioural model: slip is a countdown of remaining ignored cycles.
  int m_slip_left, m_win, m_bads, m_locked, m_inv_total, m_loss, m_bitslip, m_bad;

  typedef struct {
    logic [1:0] hdr;
    logic       vld;
    logic       exp_bad;
    logic       exp_slip;
    logic       exp_lock;
  } vec_t;
  vec_t vecs[20];

  task automatic model_reset();
    m_slip_left = 0; m_win = 0; m_bads = 0; m_locked = 0;
    m_inv_total = 0; m_loss = 0; m_bitslip = 0; m_bad = 0;
  endtask

  task automatic model_step(input logic [1:0] hdr, input logic vld);
    int is_bad;
    m_bad = 0;
    m_bitslip = 0;
    if (m_slip_left > 0) begin
      m_slip_left--;
      m_bitslip = ((SLIP_TOTAL - m_slip_left) < SLIP_HIGH) ? 1 : 0;
    end else if (vld) begin
      is_bad = (hdr == 2'b00 || hdr == 2'b11) ? 1 : 0;
      if (is_bad != 0) begin
        m_bad = 1;
        if (m_inv_total < 65535) m_inv_total++;
      end
      m_win++;
      m_bads += is_bad;
      if (m_locked == 0 && is_bad != 0) begin
        m_slip_left = SLIP_TOTAL; m_bitslip = 1; m_win = 0; m_bads = 0;
      end else if (m_locked == 0 && m_win == WINDOW) begin
        m_locked = 1; m_win = 0; m_bads = 0;
      end else if (m_locked != 0 && m_bads == INV_LIMIT) begin
        m_locked = 0;
        if (m_loss < 65535) m_loss++;
        m_slip_left = SLIP_TOTAL; m_bitslip = 1; m_win = 0; m_bads = 0;
      end else if (m_locked != 0 && m_win == WINDOW) begin
        m_win = 0; m_bads = 0;
      end
    end
  endtask

  task automatic check_output(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    check_output("model_lock",    int'(rx_block_lock),     m_locked);
    check_output("model_bitslip", int'(serdes_rx_bitslip), m_bitslip);
    check_output("model_bad_hdr", int'(rx_bad_hdr),        m_bad);
    check_output("model_inv_cnt", int'(inv_hdr_count),     m_inv_total);
    check_output("model_loss",    int'(lock_loss_count),   m_loss);
  endtask

  task automatic apply_stimulus(input logic [1:0] hdr, input logic vld);
    serdes_rx_hdr = hdr;
    serdes_rx_hdr_valid = vld;
    @(posedge clk_tb);
    #1;
    model_step(hdr, vld);
    check_model();
  endtask

  task automatic check_all_zero(input string name);
    check_output({name, "_lock"},    int'(rx_block_lock),     0);
    check_output({name, "_bitslip"}, int'(serdes_rx_bitslip), 0);
    check_output({name, "_bad"},     int'(rx_bad_hdr),        0);
    check_output({name, "_inv"},     int'(inv_hdr_count),     0);
    check_output({name, "_loss"},    int'(lock_loss_count),   0);
  endtask

  // Reset pulse placed between clock edges so its effect is purely asynchronous.
  task automatic async_reset_pulse(input string name);
    #2 rx_rst_tb = 1'b1;
    #1 check_all_zero(name);
    #1 rx_rst_tb = 1'b0;
    model_reset();
  endtask

  task automatic send_valid(input int n);
    for (int i = 0; i < n; i++) apply_stimulus((i % 2) ? 2'b01 : 2'b10, 1'b1);
  endtask

  task automatic send_bad(input int n);
    for (int i = 0; i < n; i++) apply_stimulus((i % 2) ? 2'b11 : 2'b00, 1'b1);
  endtask

  initial begin
    int slip_seen;
    int qualified;
    int pbad;
    logic [1:0] h;

    for (int i = 0; i < 9; i++) vecs[i] = '{2'b10, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[9] = '{2'b11, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 10; i < 19; i++) vecs[i] = '{2'b11, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[19] = '{2'b00, 1'b1, 1'b1, 1'b1, 1'b0};

    model_reset();
    @(posedge clk_tb);
    @(posedge clk_tb);
    #2 rx_rst_tb = 1'b0;
    check_all_zero("reset");

    // T1: 64 valid headers from reset lock on the 64th edge, no slip.
    slip_seen = 0;
    for (int i = 0; i < WINDOW; i++) begin
      apply_stimulus(2'b10, 1'b1);
      if (serdes_rx_bitslip) slip_seen = 1;
      if (i == WINDOW - 2) check_output("t1_lock_63", int'(rx_block_lock), 0);
    end
    check_output("t1_lock_64", int'(rx_block_lock), 1);
    check_output("t1_no_slip", slip_seen, 0);

    // T2: vector table, invalid on cycle 10, slip lasts 9 cycles.
    async_reset_pulse("t2_reset");
    for (int i = 0; i < 20; i++) begin
      apply_stimulus(vecs[i].hdr, vecs[i].vld);
      check_output($sformatf("vec%0d_bad", i),  int'(rx_bad_hdr),        int'(vecs[i].exp_bad));
      check_output($sformatf("vec%0d_slip", i), int'(serdes_rx_bitslip), int'(vecs[i].exp_slip));
      check_output($sformatf("vec%0d_lock", i), int'(rx_block_lock),     int'(vecs[i].exp_lock));
    end
    send_valid(SLIP_TOTAL + WINDOW);
    check_output("t2_lock", int'(rx_block_lock), 1);
    check_output("t2_inv_count", int'(inv_hdr_count), 2);

    // T3: 15 invalid in a window hold lock; 16 drop it.
    send_bad(15);
    send_valid(WINDOW - 15);
    check_output("t3_lock_held", int'(rx_block_lock), 1);
    check_output("t3_loss0", int'(lock_loss_count), 0);
    send_bad(15);
    check_output("t3_lock_15", int'(rx_block_lock), 1);
    send_bad(1);
    check_output("t3_lock_drop", int'(rx_block_lock), 0);
    check_output("t3_loss1", int'(lock_loss_count), 1);
    check_output("t3_slip", int'(serdes_rx_bitslip), 1);
    send_valid(SLIP_TOTAL + WINDOW);
    check_output("t3_relock", int'(rx_block_lock), 1);

    // T4: 16th invalid lands on window position 64.
    send_valid(WINDOW - INV_LIMIT);
    send_bad(INV_LIMIT - 1);
    check_output("t4_lock_63", int'(rx_block_lock), 1);
    send_bad(1);
    check_output("t4_lock_drop", int'(rx_block_lock), 0);
    check_output("t4_loss2", int'(lock_loss_count), 2);
    send_valid(SLIP_TOTAL);

    // T5: qualifier toggling 50%; lock after 64 qualified headers.
    qualified = 0;
    for (int i = 0; i < 2 * WINDOW; i++) begin
      apply_stimulus(2'b10, (i % 2) == 0);
      if ((i % 2) == 0) qualified++;
      if (qualified == WINDOW - 1 && (i % 2) == 0)
        check_output("t5_lock_63", int'(rx_block_lock), 0);
    end
    check_output("t5_lock", int'(rx_block_lock), 1);

    // T6: async reset while locked, then while mid-slip; relock afterwards.
    async_reset_pulse("t6_locked");
    send_bad(1);
    apply_stimulus(2'b10, 1'b1);
    apply_stimulus(2'b10, 1'b1);
    async_reset_pulse("t6_slip");
    send_valid(WINDOW);
    check_output("t6_relock", int'(rx_block_lock), 1);

    // Randomized traffic alternating clean and noisy phases.
    for (int round = 0; round < 8; round++) begin
      pbad = (round % 2) ? 4 + 6 * round : 0;
      for (int i = 0; i < 250; i++) begin
        h = ($urandom_range(0, 99) < pbad) ? ($urandom_range(0, 1) ? 2'b11 : 2'b00)
                                            : ($urandom_range(0, 1) ? 2'b01 : 2'b10);
        apply_stimulus(h, $urandom_range(0, 3) != 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
